// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and constants for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Last prescaler value before a hundredths tick; a ratio of 1 ticks every clock.
    function automatic int unsigned prescale_terminal(input int unsigned clk_hz,
                                                      input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

endpackage

// File: rtl/bcd_decade_counter.sv
// rtl/bcd_decade_counter.sv - one 0..9 decade of the cascaded BCD time register
module bcd_decade_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    // Carry out when this decade wraps from 9 back to 0.
    assign carry = inc && (digit == BCD_MAX);

    // Decade register: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - stopwatch FSM, prescaler and BCD time register (STOPWATCH_LAP_EN enables lap freeze)
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned TICK_HZ          = 100,
    parameter int unsigned NUMBER_OF_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn_start_stop,
    input  logic                          btn_lap,
    input  logic                          btn_clear,
    output logic [NUMBER_OF_DIGITS*4-1:0] number,
    output logic                          running,
    output logic                          lap_active,
    output logic                          overflow
);

    localparam int unsigned PRESC_TERM = prescale_terminal(CLK_HZ, TICK_HZ);
    localparam int unsigned PRESC_W    = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;
    localparam int unsigned NW         = NUMBER_OF_DIGITS * 4;

    sw_state_t                   state_q;
    sw_state_t                   state_d;
    logic [PRESC_W-1:0]          presc_q;
    logic                        counting;
    logic                        tick;
    logic                        clr_time;
    logic [NUMBER_OF_DIGITS-1:0] inc;
    logic [NUMBER_OF_DIGITS-1:0] carry;
    logic [NW-1:0]               time_cur;
    logic [NW-1:0]               time_next;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (presc_q == PRESC_W'(PRESC_TERM));

    // Prescaler: runs only while counting, holds in STOP so partial ticks survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clr_time) begin
            presc_q <= '0;
        end else if (counting) begin
            presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Increment enables and the value the time register takes at the next edge.
    always_comb begin
        logic lower_nines;
        inc         = '0;
        time_next   = time_cur;
        lower_nines = tick;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            inc[i]      = lower_nines;
            lower_nines = lower_nines && (time_cur[4*i +: 4] == BCD_MAX);
            if (clr_time) begin
                time_next[4*i +: 4] = 4'd0;
            end else if (inc[i]) begin
                time_next[4*i +: 4] = (time_cur[4*i +: 4] == BCD_MAX) ? 4'd0
                                                                      : time_cur[4*i +: 4] + 4'd1;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUMBER_OF_DIGITS; k++) begin : g_digit
            bcd_decade_counter u_digit (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_time),
                .inc   (inc[k]),
                .digit (time_cur[4*k +: 4]),
                .carry (carry[k])
            );
        end
    endgenerate

`ifdef STOPWATCH_LAP_EN
    logic          lap_capture;
    logic [NW-1:0] lap_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats start/stop beats lap; the losers of a cycle are dropped.
    always_comb begin
        state_d  = state_q;
        clr_time = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_capture = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                end else if (btn_start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_start_stop) begin
                    state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
                end else if (btn_lap) begin
                    state_d     = ST_LAP;
                    lap_capture = 1'b1;
`endif
                end
            end
            ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (btn_start_stop) begin
                    state_d = ST_STOP;
                end else if (btn_lap) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (btn_clear) begin
                    state_d  = ST_IDLE;
                    clr_time = 1'b1;
                end else if (btn_start_stop) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs, loaded with the post-edge view so they track the time register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number   <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            running  <= (state_d == ST_RUN) || (state_d == ST_LAP);
            overflow <= clr_time ? 1'b0 : (overflow | (&carry));
`ifdef STOPWATCH_LAP_EN
            number   <= (state_d == ST_LAP) ? (lap_capture ? time_next : lap_q) : time_next;
`else
            number   <= time_next;
`endif
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap latch and freeze flag; the latch takes the incremented time if a tick coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q      <= '0;
            lap_active <= 1'b0;
        end else begin
            if (lap_capture) begin
                lap_q <= time_next;
            end
            lap_active <= (state_d == ST_LAP);
        end
    end
`else
    assign lap_active = 1'b0;
`endif

endmodule
